fifo_pop_stream_adapter: RTL

FIFO_POP_STREAM_ADAPTER -- requirements
Module: fifo_pop_stream_adapter

---
 rtl/fifo_pop_stream_adapter.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_pop_stream_adapter.sv
// Show-ahead FIFO pop to valid/ready stream adapter with a two-entry (output + skid) buffer.
// Optional transfer counter enabled by defining FIFO_POP_STREAM_ADAPTER_XFER_COUNT_EN.
module fifo_pop_stream_adapter #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [15:0]      xfer_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_t;

  state_t           r_state;
  logic [width-1:0] r_out;
  logic [width-1:0] r_skid;
  logic             r_valid;
  logic [1:0]       r_occ;

  logic w_pop;
  logic w_xfer;

  // Pop depends only on held state, never on out_ready; rst gates it so nothing is popped in reset.
  assign w_pop  = ~rst & ~fifo_empty & (r_state != TWO);
  assign w_xfer = r_valid & out_ready;

  assign fifo_pop  = w_pop;
  assign out_valid = r_valid;
  assign out_data  = r_out;
  assign occupancy = r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_occ   <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_out   <= fifo_read_data;
            r_state <= ONE;
            r_valid <= 1'b1;
            r_occ   <= 2'd1;
          end
        end
        ONE: begin
          if (w_pop && w_xfer) begin
            r_out <= fifo_read_data;
          end else if (w_pop) begin
            r_skid  <= fifo_read_data;
            r_state <= TWO;
            r_occ   <= 2'd2;
          end else if (w_xfer) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_occ   <= 2'd0;
          end
        end
        TWO: begin
          if (w_xfer) begin
            r_out   <= r_skid;
            r_state <= ONE;
            r_occ   <= 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_occ   <= 2'd0;
        end
      endcase
    end
  end

`ifdef FIFO_POP_STREAM_ADAPTER_XFER_COUNT_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xfer_count <= '0;
    end else if (w_xfer) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`else
  assign xfer_count = '0;
`endif

endmodule
